// File: rtl/conv_drain.sv
// Snapshots the accumulator vector after every ACC_LEN beats and streams it out one lane per handshake.
// out_valid rises one edge after the window's last beat; a window that completes while draining is dropped and flagged.
module conv_drain #(
  parameter int LANES   = 16,
  parameter int LANE_W  = 32,
  parameter int ACC_LEN = 64,
  parameter int CNT_W   = 16,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int BW     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LANES*LANE_W-1:0] acc_in,
  output logic [LANE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LW-1:0]           out_lane,
  output logic                    out_last,
  output logic                    out_special,
  output logic                    overrun,
  input  logic                    clr_ovr,
  output logic [CNT_W-1:0]        win_cnt
);

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                  state;
  logic [BW-1:0]           beat_cnt;
  logic                    pend;
  logic [LANES*LANE_W-1:0] shadow;

  logic          last_beat;
  logic          hs;
  logic          final_hs;
  logic          drop;
  logic [LW-1:0] next_lane;

  assign last_beat = in_valid && (beat_cnt == BW'(ACC_LEN - 1));
  assign hs        = out_valid && out_ready;
  assign final_hs  = hs && out_last;
  // A window completing on the final-lane handshake is captured, not dropped.
  assign drop      = pend && (state == DRAIN) && !final_hs;
  assign next_lane = out_lane + 1'b1;

  assign out_special = (out_data[LANE_W-2:LANE_W-9] == 8'hFF);

  // pend trails the last beat by one cycle so acc_in reflects the accumulator's output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      pend     <= 1'b0;
    end else begin
      pend <= last_beat;
      if (in_valid) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
      win_cnt   <= '0;
    end else begin
      overrun <= drop || (overrun && !clr_ovr);
      case (state)
        EMPTY: begin
          if (pend) begin
            state     <= DRAIN;
            shadow    <= acc_in;
            out_valid <= 1'b1;
            out_data  <= acc_in[LANE_W-1:0];
            out_lane  <= '0;
            out_last  <= (LANES == 1);
          end
        end
        DRAIN: begin
          if (final_hs) begin
            win_cnt <= win_cnt + 1'b1;
            if (pend) begin
              shadow    <= acc_in;
              out_data  <= acc_in[LANE_W-1:0];
              out_lane  <= '0;
              out_last  <= (LANES == 1);
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end else if (hs) begin
            out_lane <= next_lane;
            out_data <= shadow[int'(next_lane)*LANE_W +: LANE_W];
            out_last <= (next_lane == LW'(LANES - 1));
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_drain.sv
// Scoreboard bench for conv_drain with LANES=4, ACC_LEN=4.
module tb_conv_drain;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] acc_in;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_lane;
  logic         out_last;
  logic         out_special;
  logic         overrun;
  logic         clr_ovr;
  logic [15:0]  win_cnt;

  conv_drain #(.LANES(4), .LANE_W(32), .ACC_LEN(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .acc_in(acc_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane(out_lane), .out_last(out_last), .out_special(out_special),
    .overrun(overrun), .clr_ovr(clr_ovr), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  lane;
    logic        last;
    logic        spec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_win(input logic [31:0] a0, a1, a2, a3, input logic [3:0] spec);
    logic [31:0] v[4];
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < 4; i++) q.push_back('{v[i], 2'(i), i == 3, spec[i]});
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_hs timeout got=%0d exp=%0d", hs_cnt, target);
    end
  endtask

  // Monitor: stall stability, then scoreboard pop on each handshake.
  logic        stall_prev = 1'b0;
  logic [31:0] pd;
  logic [1:0]  pl;
  logic        plast;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, pd);
        chk("stall_lane", {30'd0, out_lane}, {30'd0, pl});
        chk("stall_last", {31'd0, out_last}, {31'd0, plast});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got=%h exp=none", out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", out_data, e.d);
          chk("lane", {30'd0, out_lane}, {30'd0, e.lane});
          chk("last", {31'd0, out_last}, {31'd0, e.last});
          chk("special", {31'd0, out_special}, {31'd0, e.spec});
        end
        hs_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data; pl = out_lane; plast = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; acc_in = '0; out_ready = 1'b0; clr_ovr = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_lane", {30'd0, out_lane}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_win", {16'd0, win_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic window, consumer always ready.
    out_ready = 1'b1;
    acc_in = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    push_win(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 4'b0000);
    beats(4);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_lane0", out_data, 32'h3F800000);
    acc_in = {4{32'hDEADBEEF}};
    wait_hs(4);
    chk("w1_win", {16'd0, win_cnt}, 32'd1);
    chk("w1_ovr", {31'd0, overrun}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1,...
    acc_in = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
    push_win(32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 4'b0000);
    beats(4);
    @(posedge clk); #1;
    acc_in = {4{32'h12345678}};
    n = 0;
    while (hs_cnt < 8 && n < 100) begin
      out_ready = (n % 3) == 0;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    chk("bp_hs", hs_cnt, 32'd8);
    repeat (2) @(posedge clk); #1;
    chk("bp_no_extra", hs_cnt, 32'd8);
    chk("bp_win", {16'd0, win_cnt}, 32'd2);

    // Overrun: a second window completes while stalled.
    acc_in = {32'h42000000, 32'h41C00000, 32'h41800000, 32'h41400000};
    push_win(32'h41400000, 32'h41800000, 32'h41C00000, 32'h42000000, 4'b0000);
    beats(4);
    @(posedge clk); #1;
    acc_in = {4{32'hBAADF00D}};
    beats(4);
    repeat (2) @(posedge clk); #1;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_hold_data", out_data, 32'h41400000);
    chk("ovr_hold_lane", {30'd0, out_lane}, 32'd0);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
    beats(4);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    chk("ovr_clr2", {31'd0, overrun}, 32'd0);
    out_ready = 1'b1;
    wait_hs(12);
    chk("ovr_win", {16'd0, win_cnt}, 32'd3);

    // Back-to-back windows: second pend lands on the lane-3 handshake.
    for (int i = 0; i < 8; i++) begin
      acc_in = (i >= 5) ? {32'h43800000, 32'h43000000, 32'h42800000, 32'h42000000}
                        : {32'h3E800000, 32'h3F000000, 32'h3F400000, 32'hBF800000};
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 0) begin
        push_win(32'hBF800000, 32'h3F400000, 32'h3F000000, 32'h3E800000, 4'b0000);
        push_win(32'h42000000, 32'h42800000, 32'h43000000, 32'h43800000, 4'b0000);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_lane0", {30'd0, out_lane}, 32'd0);
    chk("b2b_data0", out_data, 32'h42000000);
    chk("b2b_win", {16'd0, win_cnt}, 32'd4);
    chk("b2b_ovr", {31'd0, overrun}, 32'd0);
    wait_hs(20);
    chk("b2b_win2", {16'd0, win_cnt}, 32'd5);

    // Exponent 0xFF detection.
    acc_in = {32'h7F7FFFFF, 32'hFF800000, 32'h7FC00000, 32'h3F800000};
    push_win(32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h7F7FFFFF, 4'b0110);
    beats(4);
    wait_hs(24);
    chk("spec_win", {16'd0, win_cnt}, 32'd6);

    // Asynchronous reset during lane 1.
    acc_in = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    push_win(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 4'b0000);
    beats(4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pre_rst_lane1", {30'd0, out_lane}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_lane", {30'd0, out_lane}, 32'd0);
    chk("arst_win", {16'd0, win_cnt}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = hs_cnt;
    beats(3);
    repeat (4) @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    chk("post_rst_hs", hs_cnt, base);
    acc_in = {32'h40C00000, 32'h40A00000, 32'h40800000, 32'h40400000};
    push_win(32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 4'b0000);
    beats(1);
    wait_hs(base + 4);
    chk("post_rst_win", {16'd0, win_cnt}, 32'd1);
    chk("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
